accumulator_window_controller: RTL and testbench

//  Sequences one inference window over an array of NUM_NEURONS spike accumulators.

---
 rtl/snn_ctrl_pkg.sv | 18 +
 rtl/argmax_tracker.sv | 50 +++++
 rtl/accumulator_window_controller.sv | 160 ++++++++++++++++
 tb/tb_accumulator_window_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the SNN inference-window controller: FSM states and defaults.
package snn_ctrl_pkg;

    // Window sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_READ   = 3'd4,
        ST_DONE   = 3'd5
    } ctrl_state_e;

    localparam int DEFAULT_NUM_NEURONS = 10;
    localparam int DEFAULT_TIMER_WIDTH = 5;
    localparam int DEFAULT_WINDOW_LEN  = 16;

endpackage

// File: rtl/argmax_tracker.sv
// Running maximum over a stream of (index, count) beats.
// The first beat of a window always captures; later beats capture only when strictly
// greater, so ties resolve to the lower index. Exposes the post-beat value so the
// caller can latch a result on the same edge as the final beat.
module argmax_tracker #(
    parameter int IDX_WIDTH = 4,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 sample,
    input  logic                 first,
    input  logic [IDX_WIDTH-1:0] in_index,
    input  logic [CNT_WIDTH-1:0] in_count,
    output logic [IDX_WIDTH-1:0] next_index,
    output logic [CNT_WIDTH-1:0] next_count
);

    logic [IDX_WIDTH-1:0] max_index_q, max_index_d;
    logic [CNT_WIDTH-1:0] max_count_q, max_count_d;

    // Next running max: clear wins, otherwise first-or-strictly-greater capture
    always_comb begin
        max_index_d = max_index_q;
        max_count_d = max_count_q;
        if (clear) begin
            max_index_d = '0;
            max_count_d = '0;
        end else if (sample && (first || (in_count > max_count_q))) begin
            max_index_d = in_index;
            max_count_d = in_count;
        end
    end

    // Running max registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_index_q <= '0;
            max_count_q <= '0;
        end else begin
            max_index_q <= max_index_d;
            max_count_q <= max_count_d;
        end
    end

    assign next_index = max_index_d;
    assign next_count = max_count_d;

endmodule

// File: rtl/accumulator_window_controller.sv
// Sequences one inference window over the spike accumulators:
// clear, gate spikes for WINDOW_LEN timesteps, settle, stream counts out, report argmax.
module accumulator_window_controller
    import snn_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
    parameter int TIMER_WIDTH = DEFAULT_TIMER_WIDTH,
    parameter int WINDOW_LEN  = DEFAULT_WINDOW_LEN,
    localparam int IDX_WIDTH  = $clog2(NUM_NEURONS),
    localparam int TS_WIDTH   = $clog2(WINDOW_LEN + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    output logic                               busy,
    output logic                               acc_clear_n,
    output logic                               spike_gate,
    output logic [TS_WIDTH-1:0]                timestep,
    input  logic [NUM_NEURONS*TIMER_WIDTH-1:0] acc_flat,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic [IDX_WIDTH-1:0]               rd_index,
    output logic [TIMER_WIDTH-1:0]             rd_count,
    output logic                               result_valid,
    output logic [IDX_WIDTH-1:0]               result_index,
    output logic [TIMER_WIDTH-1:0]             result_count
);

    // The window length bound is what keeps every accumulator from wrapping
    if (WINDOW_LEN < 1 || WINDOW_LEN > (2**TIMER_WIDTH) - 1) begin : g_bad_window_len
        $error("WINDOW_LEN must be in 1..2**TIMER_WIDTH-1");
    end

    localparam int MUX_DEPTH = 2**IDX_WIDTH;
    localparam logic [TS_WIDTH-1:0]  LAST_TS  = TS_WIDTH'(WINDOW_LEN - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    ctrl_state_e               state_q, state_d;
    logic [TS_WIDTH-1:0]       timestep_q, timestep_d;
    logic [IDX_WIDTH-1:0]      rd_index_q, rd_index_d;
    logic [IDX_WIDTH-1:0]      result_index_q, result_index_d;
    logic [TIMER_WIDTH-1:0]    result_count_q, result_count_d;

    logic [TIMER_WIDTH-1:0]    count_arr [MUX_DEPTH];
    logic                      beat_xfer;
    logic [IDX_WIDTH-1:0]      track_index;
    logic [TIMER_WIDTH-1:0]    track_count;

    // Unpack the flat count bus; unused mux slots read as zero
    for (genvar gi = 0; gi < MUX_DEPTH; gi++) begin : g_unpack
        if (gi < NUM_NEURONS) begin : g_used
            assign count_arr[gi] = acc_flat[gi*TIMER_WIDTH +: TIMER_WIDTH];
        end else begin : g_unused
            assign count_arr[gi] = '0;
        end
    end

    assign rd_count  = count_arr[rd_index_q];
    // An aborted cycle never counts as an accepted beat
    assign beat_xfer = (state_q == ST_READ) && rd_ready && !abort;

    argmax_tracker #(
        .IDX_WIDTH (IDX_WIDTH),
        .CNT_WIDTH (TIMER_WIDTH)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == ST_CLEAR),
        .sample     (beat_xfer),
        .first      (rd_index_q == '0),
        .in_index   (rd_index_q),
        .in_count   (rd_count),
        .next_index (track_index),
        .next_count (track_count)
    );

    // Next-state and datapath updates; abort overrides everything outside IDLE
    always_comb begin
        state_d        = state_q;
        timestep_d     = timestep_q;
        rd_index_d     = rd_index_q;
        result_index_d = result_index_q;
        result_count_d = result_count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                timestep_d = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (timestep_q == LAST_TS) begin
                    state_d = ST_SETTLE;
                end else begin
                    timestep_d = timestep_q + TS_WIDTH'(1);
                end
            end
            ST_SETTLE: begin
                rd_index_d = '0;
                state_d    = ST_READ;
            end
            ST_READ: begin
                if (rd_ready) begin
                    if (rd_index_q == LAST_IDX) begin
                        // Latch the max including this final beat
                        rd_index_d     = '0;
                        result_index_d = track_index;
                        result_count_d = track_count;
                        state_d        = ST_DONE;
                    end else begin
                        rd_index_d = rd_index_q + IDX_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d        = ST_IDLE;
            rd_index_d     = rd_index_q;
            result_index_d = result_index_q;
            result_count_d = result_count_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            timestep_q     <= '0;
            rd_index_q     <= '0;
            result_index_q <= '0;
            result_count_q <= '0;
        end else begin
            state_q        <= state_d;
            timestep_q     <= timestep_d;
            rd_index_q     <= rd_index_d;
            result_index_q <= result_index_d;
            result_count_q <= result_count_d;
        end
    end

    // Moore outputs; acc_clear_n also follows rst so accumulators clear during reset
    assign busy         = (state_q != ST_IDLE);
    assign acc_clear_n  = !(rst || (state_q == ST_CLEAR));
    assign spike_gate   = (state_q == ST_RUN);
    assign rd_valid     = (state_q == ST_READ);
    assign result_valid = (state_q == ST_DONE);
    assign timestep     = timestep_q;
    assign rd_index     = rd_index_q;
    assign result_index = result_index_q;
    assign result_count = result_count_q;

endmodule

// File: tb/tb_accumulator_window_controller.sv
// Scoreboard bench: window tasks push expected beats/results, a negedge monitor pops and compares.
module tb_accumulator_window_controller;

    localparam int NN = 10;
    localparam int TW = 5;
    localparam int WL = 16;
    localparam int IW = 4;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          rd_ready = 1'b0;
    logic          busy, acc_clear_n, spike_gate, rd_valid, result_valid;
    logic [SW-1:0] timestep;
    logic [NN*TW-1:0] acc_flat;
    logic [IW-1:0] rd_index, result_index;
    logic [TW-1:0] rd_count, result_count;

    typedef struct { int idx; int cnt; } beat_t;
    beat_t beat_q[$];
    beat_t res_q[$];

    int total = 0;
    int bad = 0;
    int results_seen = 0;

    int vec_cnt [5][NN];
    int exp_idx [5];
    int exp_cnt [5];
    int target  [NN];
    logic [TW-1:0] acc [NN];

    always #5 clk = ~clk;

    accumulator_window_controller #(
        .NUM_NEURONS (NN),
        .TIMER_WIDTH (TW),
        .WINDOW_LEN  (WL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .acc_clear_n  (acc_clear_n),
        .spike_gate   (spike_gate),
        .timestep     (timestep),
        .acc_flat     (acc_flat),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_index     (rd_index),
        .rd_count     (rd_count),
        .result_valid (result_valid),
        .result_index (result_index),
        .result_count (result_count)
    );

    // Accumulator model: neuron i spikes on every gated timestep until it reaches target[i]
    always @(posedge clk) begin
        for (int i = 0; i < NN; i++) begin
            if (!acc_clear_n) acc[i] <= '0;
            else if (spike_gate && int'(acc[i]) < target[i]) acc[i] <= acc[i] + 1'b1;
        end
    end

    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < NN; i++) acc_flat[i*TW +: TW] = acc[i];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every transferred beat and every result pulse against the queues
    initial begin : monitor
        bit prev_stall = 1'b0;
        bit prev_rv    = 1'b0;
        int prev_idx   = 0;
        int prev_cnt   = 0;
        beat_t b;
        forever begin
            @(negedge clk);
            if (rd_valid && prev_stall) begin
                chk("stall_index_stable", int'(rd_index), prev_idx);
                chk("stall_count_stable", int'(rd_count), prev_cnt);
            end
            if (rd_valid && rd_ready) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_index", int'(rd_index), b.idx);
                    chk("beat_count", int'(rd_count), b.cnt);
                    $display("beat idx=%0d cnt=%0d", rd_index, rd_count);
                end
            end
            if (prev_rv) chk("result_pulse_width", int'(result_valid), 0);
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    b = res_q.pop_front();
                    chk("result_index", int'(result_index), b.idx);
                    chk("result_count", int'(result_count), b.cnt);
                    $display("result idx=%0d cnt=%0d", result_index, result_count);
                end
                results_seen++;
            end
            prev_rv    = result_valid;
            prev_stall = rd_valid && !rd_ready;
            prev_idx   = int'(rd_index);
            prev_cnt   = int'(rd_count);
        end
    end

    task automatic load_targets(input int v);
        for (int i = 0; i < NN; i++) target[i] = vec_cnt[v][i];
    endtask

    task automatic push_expect(input int v);
        beat_t b;
        for (int i = 0; i < NN; i++) begin
            b.idx = i;
            b.cnt = vec_cnt[v][i];
            beat_q.push_back(b);
        end
        b.idx = exp_idx[v];
        b.cnt = exp_cnt[v];
        res_q.push_back(b);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One full window; mode 1 stalls the consumer two cycles out of three,
    // poke drives stray start pulses while busy
    task automatic run_window(input int v, input int mode, input bit poke);
        int r0, gates, cyc;
        load_targets(v);
        push_expect(v);
        r0 = results_seen;
        rd_ready = (mode == 0);
        pulse_start();
        gates = 0;
        cyc = 0;
        while (results_seen == r0 && cyc < 400) begin
            @(negedge clk);
            if (spike_gate) gates++;
            @(posedge clk); #1;
            cyc++;
            rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            start = poke && (cyc == 6 || cyc == 22);
        end
        start = 1'b0;
        rd_ready = 1'b1;
        chk("window_completed", int'(results_seen != r0), 1);
        chk("gated_cycles", gates, WL);
        @(negedge clk);
        chk("idle_after_done", int'(busy), 0);
        chk("beats_left", beat_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("no_restart", int'(busy), 0);
    endtask

    initial begin : stimulus
        int n;
        // Directed vectors and hand-computed argmax
        for (int i = 0; i < NN; i++) begin
            vec_cnt[0][i] = 16;
            vec_cnt[2][i] = i;
            vec_cnt[3][i] = 0;
            vec_cnt[4][i] = (i == 9) ? 15 : 1;
        end
        vec_cnt[1] = '{3, 7, 7, 2, 0, 1, 5, 6, 4, 0};
        exp_idx = '{0, 1, 9, 0, 9};
        exp_cnt = '{16, 7, 9, 0, 15};
        for (int i = 0; i < NN; i++) target[i] = 0;

        // Reset behaviour
        #2;
        chk("rst_acc_clear_n", int'(acc_clear_n), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_spike_gate", int'(spike_gate), 0);
        chk("idle_acc_clear_n", int'(acc_clear_n), 1);
        chk("idle_result_valid", int'(result_valid), 0);
        chk("idle_rd_valid", int'(rd_valid), 0);
        chk("idle_timestep", int'(timestep), 0);
        chk("idle_rd_index", int'(rd_index), 0);
        chk("idle_result_index", int'(result_index), 0);
        chk("idle_result_count", int'(result_count), 0);

        run_window(0, 0, 1'b0);   // all spikes: every count 16
        run_window(1, 0, 1'b0);   // tie between neurons 1 and 2
        run_window(2, 1, 1'b1);   // stalled readout, stray starts

        // Abort in RUN at timestep 5
        load_targets(4);
        pulse_start();
        n = 0;
        while (!(spike_gate && timestep == 5) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_ts5", int'(spike_gate && timestep == 5), 1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_spike_gate", int'(spike_gate), 0);
        chk("abort_keep_index", int'(result_index), 9);
        chk("abort_keep_count", int'(result_count), 9);
        run_window(4, 0, 1'b0);

        // Reset mid-READ
        load_targets(0);
        push_expect(0);
        pulse_start();
        n = 0;
        while (!(rd_valid && rd_index == 4) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("reached_read", int'(rd_valid && rd_index == 4), 1);
        rst = 1'b1;
        #1;
        chk("midrst_acc_clear_n", int'(acc_clear_n), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rd_valid", int'(rd_valid), 0);
        chk("midrst_result_index", int'(result_index), 0);
        chk("midrst_result_count", int'(result_count), 0);
        beat_q.delete();
        res_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_acc_clear_n", int'(acc_clear_n), 1);
        run_window(3, 0, 1'b0);   // all-zero counts -> index 0

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
